// File: rtl/ms_wr_buffer.sv
// Write-command buffer in front of the ms_if slave stage.
// Producer writes are queued in a small show-ahead FIFO and drained in
// order whenever the slave raises sready, so that short slave
// back-pressure does not stall the producer.
module ms_wr_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    output logic [AW-1:0]            out_addr,
    output logic [DW-1:0]            out_data,
    input  logic                     sready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               stall_cnt,
    input  logic                     clr_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic             push, pop;

    // Handshake status comes from the stored level only, so sready never reaches in_ready.
    always_comb begin
        in_ready  = (level_q != LW'(DEPTH));
        out_valid = (level_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & sready;
        {out_addr, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;
        level     = level_q;
        stall_cnt = stall_cnt_q;
    end

    // Next-state for pointers, occupancy and the saturating stall counter.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        stall_cnt_d = stall_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (clr_stall) begin
            stall_cnt_d = 8'd0;
        end else if (in_valid && !in_ready && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Entry storage; contents need no reset because empty output is forced to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_addr, in_data};
        end
    end

endmodule

// File: tb/tb_ms_wr_buffer.sv
// Self-checking bench for ms_wr_buffer: queue-based reference model,
// per-cycle compare process, directed scenarios and a random phase.
module tb_ms_wr_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          sready;
    logic [2:0]    level;
    logic [7:0]    stall_cnt;
    logic          clr_stall;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [AW+DW-1:0] mq[$];
    int               m_stall = 0;
    bit               prev_hold = 0;
    logic [AW+DW-1:0] prev_word;
    bit               cmp_en = 0;

    ms_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .sready    (sready),
        .level     (level),
        .stall_cnt (stall_cnt),
        .clr_stall (clr_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Reference model: advance the queue and stall count on each edge
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_stall   = 0;
            prev_hold = 0;
        end else begin
            bit full, push, pop;
            full = (mq.size() == DEPTH);
            push = in_valid && !full;
            pop  = (mq.size() != 0) && sready;
            if (prev_hold) begin
                chk("producer_hold_valid", int'(in_valid), 1);
                chk("producer_hold_word", int'({in_addr, in_data}), int'(prev_word));
            end
            if (clr_stall) m_stall = 0;
            else if (in_valid && full && m_stall < 255) m_stall++;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({in_addr, in_data});
            prev_hold = in_valid && full;
            prev_word = {in_addr, in_data};
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        if (rstn && cmp_en) begin
            chk("level", int'(level), mq.size());
            chk("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("stall_cnt", int'(stall_cnt), m_stall);
            if (mq.size() != 0)
                chk("head_word", int'({out_addr, out_data}), int'(mq[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one producer word; hold it until accepted or the cycle budget runs out
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int budget);
        bit acc;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        acc      = 0;
        for (int n = 0; n < budget && !acc; n++) begin
            acc = in_ready;
            step();
        end
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_addr"}, int'(out_addr), int'(a));
        chk({name, "_data"}, int'(out_data), int'(d));
    endtask

    task automatic drain();
        sready = 1'b1;
        for (int n = 0; n < 8; n++) step();
        chk("drain_empty", int'(level), 0);
    endtask

    initial begin
        logic [DW-1:0] exp_d [5];
        bit acc;
        exp_d[0] = 8'h00; exp_d[1] = 8'h04; exp_d[2] = 8'h08;
        exp_d[3] = 8'h0C; exp_d[4] = 8'h10;

        rstn = 1'b0; in_valid = 0; in_addr = 0; in_data = 0;
        sready = 0; clr_stall = 0;
        step(); step();
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        rstn = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        cmp_en = 1;

        // Single write with 1-cycle latency
        sready = 1'b1;
        applyStimulus(2'd1, 8'h5A, 4);
        checkOutput("single", 2'd1, 8'h5A);
        step();
        chk("single_popped_level", int'(level), 0);

        // Fill while the slave stalls, then drain in order
        sready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), DW'(i * 4), 4);
        chk("fill_level", int'(level), 4);
        chk("fill_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; in_addr = 2'd0; in_data = 8'h10;
        step(); step(); step();
        chk("fill_stall3", int'(stall_cnt), 3);
        sready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain_order", int'(out_data), int'(exp_d[k]));
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        drain();
        clr_stall = 1'b1; step(); clr_stall = 1'b0;
        chk("clear_after_fill", int'(stall_cnt), 0);

        // Streaming with a ready slave: occupancy never exceeds one
        sready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_addr = AW'(i % 4); in_data = DW'((i % 4) * 4);
            step();
            chk("stream_level_le1", int'(level <= 3'd1), 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_no_stall", int'(stall_cnt), 0);
        chk("stream_empty", int'(level), 0);

        // Simultaneous push and pop at level 2
        sready = 1'b0;
        applyStimulus(2'd1, 8'h11, 4);
        applyStimulus(2'd2, 8'h22, 4);
        chk("pp_level_before", int'(level), 2);
        sready = 1'b1;
        applyStimulus(2'd3, 8'h33, 4);
        chk("pp_level_after", int'(level), 2);
        checkOutput("pp_head", 2'd2, 8'h22);
        drain();

        // Asynchronous reset with three entries stored
        sready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(AW'(i), DW'(8'hA0 + i), 4);
        chk("mid_level", int'(level), 3);
        @(posedge clk);
        #3 rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_level", int'(level), 0);
        step();
        rstn = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        applyStimulus(2'd2, 8'h33, 4);
        checkOutput("post_rst_first", 2'd2, 8'h33);
        drain();

        // Stall counter saturation and clear priority
        sready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), DW'(8'hC0 + i), 4);
        in_valid = 1'b1; in_addr = 2'd3; in_data = 8'hEE;
        for (int n = 0; n < 300; n++) step();
        chk("stall_saturate", int'(stall_cnt), 255);
        clr_stall = 1'b1; step(); clr_stall = 1'b0;
        chk("stall_clear", int'(stall_cnt), 0);
        step();
        chk("stall_after_clear", int'(stall_cnt), 1);
        sready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        drain();

        // Random traffic; the producer holds a refused word
        for (int n = 0; n < 3000; n++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_addr  = AW'($urandom);
                in_data  = DW'($urandom);
            end
            sready    = ($urandom_range(0, 2) != 0);
            clr_stall = ($urandom_range(0, 31) == 0);
            acc = in_valid && in_ready;
            step();
        end
        in_valid = 1'b0; clr_stall = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ms_wr_buffer.md
Name: ms_wr_buffer

Overview:
- Write-command buffer placed directly upstream of the ms_if slave stage.
- Accepts addr/data writes from a producer over a valid/ready handshake and stores them in a small FIFO.
- Drains entries in order onto slave-style addr/data lines, throttled by the slave's sready.
- Absorbs the slave's periodic sready de-assertion so the producer is not stalled on every slave back-pressure cycle.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, 2, address width; matches the slave register index.
- DW, 8, data width.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a write to offer
- in_ready  output  1  buffer can accept this cycle
- in_addr  input  AW  producer write address
- in_data  input  DW  producer write data
- out_valid  output  1  head entry presented to slave
- out_addr  output  AW  head entry address
- out_data  output  DW  head entry data
- sready  input  1  slave accepts the presented entry this cycle
- level  output  $clog2(DEPTH)+1  current number of stored entries
- stall_cnt  output  8  saturating count of producer stall cycles
- clr_stall  input  1  synchronous clear of stall_cnt

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset (asynchronous, any time, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, level=0, out_valid=0, stall_cnt=0; in_ready=1 once rstn is high.
  - FIFO contents are don't-care.
  - out_addr and out_data are 0 while empty after reset.
- Push: in_valid & in_ready at posedge. Entry is written at wr_ptr, wr_ptr increments modulo DEPTH, and level increments.
- Pop: out_valid & sready at posedge. rd_ptr increments modulo DEPTH and level decrements.
- in_ready = (level != DEPTH). No combinational path from sready to in_ready, so a full FIFO refuses a push even in a pop cycle.
- Output timing:
  - Show-ahead: out_valid = (level != 0); out_addr/out_data = mem[rd_ptr].
  - Outputs hold stable while out_valid & !sready.
- Latency: a push into an empty FIFO appears on out_valid the cycle after the push edge, giving 1-cycle minimum latency.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both pointers advance.
- Empty: push and pop cannot coincide because out_valid=0. sready is ignored while empty.
- Full: the producer must hold in_valid/in_addr/in_data until in_ready. Data is never dropped.
- Ordering: strict FIFO; no address merging or reordering.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from level, not from pointer compare.
- stall_cnt:
  - Increments on each cycle with in_valid & !in_ready; saturates at 255.
  - clr_stall has priority and forces 0 on that edge, even if a stall occurs in the same cycle.
- State: pointers, level, storage and stall_cnt only. No further FSM; control is derived from level.
- Assertions:
  - level never exceeds DEPTH and never underflows.
  - Producer stability: in_addr/in_data do not change while in_valid & !in_ready. The bench checks this; the RTL does not correct it.

Test Plan:
- Reset then single write: push (addr=1, data=0x5A) with sready=1.
  - out_valid=1 with 1/0x5A one cycle after the push edge.
  - Popped the following edge; level returns to 0.
- Fill while slave stalls: sready=0, push 4 writes (0/0x00, 1/0x04, 2/0x08, 3/0x0C).
  - level=4 and in_ready=0.
  - 5th in_valid held 3 cycles gives stall_cnt=3.
  - Then sready=1 drains in the exact order above.
- Streaming: sready=1, push 20 consecutive writes with addr incrementing mod 4 and data=addr*4.
  - level stays <= 1, no stalls, output sequence identical to input, pointers wrap 5 times.
- Simultaneous push/pop at level=2: level stays 2 and head advances to the next entry.
- Mid-operation reset: with level=3, assert rstn low between clock edges.
  - out_valid=0 and level=0 immediately, without waiting for a clock edge.
  - After release, a new push of 2/0x33 is the first entry out.
- stall_cnt saturation and clear:
  - Hold a full FIFO with in_valid=1 for 300 cycles; stall_cnt=255.
  - clr_stall pulse during an ongoing stall gives 0 on that edge and 1 on the next edge.
